// File: rtl/nco_regs_pkg.sv
// Shared constants and types for the AXI4-Lite NCO register block:
// register offsets, ID value, response codes, FSM states and address decode.
package nco_regs_pkg;

    localparam logic [31:0] OFS_STEP_SHADOW = 32'h0000_0000;
    localparam logic [31:0] OFS_CTRL        = 32'h0000_0004;
    localparam logic [31:0] OFS_COMMIT      = 32'h0000_0008;
    localparam logic [31:0] OFS_STATUS      = 32'h0000_000C;
    localparam logic [31:0] OFS_ID          = 32'h0000_0010;

    localparam logic [31:0] ID_VALUE = 32'h4D41_5348;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } wstate_e;
    typedef enum logic { R_IDLE, R_DATA } rstate_e;

    typedef enum logic [2:0] {
        SEL_STEP,
        SEL_CTRL,
        SEL_COMMIT,
        SEL_STATUS,
        SEL_ID,
        SEL_NONE
    } reg_sel_e;

    // Word-aligned decode: the two byte-offset bits never select a register.
    function automatic reg_sel_e decode_addr(input logic [31:0] addr);
        case (addr & ~32'h3)
            OFS_STEP_SHADOW: return SEL_STEP;
            OFS_CTRL:        return SEL_CTRL;
            OFS_COMMIT:      return SEL_COMMIT;
            OFS_STATUS:      return SEL_STATUS;
            OFS_ID:          return SEL_ID;
            default:         return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/axil_nco_regs.sv
// AXI4-Lite register block for an NCO phase step with shadow/commit semantics.
// Define AXIL_NCO_REGS_READBACK_EN to read back STEP_SHADOW and CTRL contents.
module axil_nco_regs
    import nco_regs_pkg::*;
#(
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  aclk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [31:0]           s_axil_wdata,
    input  logic [3:0]            s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,

    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [31:0]           s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,

    output logic [ACC_WIDTH-1:0]  nco_step,
    output logic                  nco_step_update,
    output logic                  nco_step_enable,
    output logic                  dither_enable,
    input  logic                  mmcm_locked
);

    wstate_e               wstate_q, wstate_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [31:0]           w_data_q, w_data_d;
    logic [3:0]            w_strb_q, w_strb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;

    rstate_e               rstate_q, rstate_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic [ACC_WIDTH-1:0]  step_shadow_q, step_shadow_d;
    logic [ACC_WIDTH-1:0]  nco_step_q, nco_step_d;
    logic                  step_update_q, step_update_d;
    logic [1:0]            ctrl_q, ctrl_d;
    logic                  pending_q, pending_d;

    reg_sel_e              wr_sel, rd_sel;
    logic [31:0]           shadow_ext, shadow_merged;
    logic [31:0]           rd_data;
    logic [1:0]            rd_resp;

    assign wr_sel     = decode_addr(32'(aw_addr_q));
    assign shadow_ext = 32'(step_shadow_q);

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            shadow_merged[8*b +: 8] = w_strb_q[b] ? w_data_q[8*b +: 8] : shadow_ext[8*b +: 8];
        end
    end

    // Write channel: capture AW and W independently, then update and respond.
    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no path can infer a latch.
        wstate_d      = wstate_q;
        aw_held_d     = aw_held_q;
        w_held_d      = w_held_q;
        aw_addr_d     = aw_addr_q;
        w_data_d      = w_data_q;
        w_strb_d      = w_strb_q;
        bvalid_d      = bvalid_q;
        bresp_d       = bresp_q;
        step_shadow_d = step_shadow_q;
        ctrl_d        = ctrl_q;
        pending_d     = pending_q;
        nco_step_d    = nco_step_q;
        step_update_d = 1'b0;

        case (wstate_q)
            W_IDLE: begin
                if (awready_q && s_axil_awvalid) begin
                    aw_held_d = 1'b1;
                    aw_addr_d = s_axil_awaddr;
                end
                if (wready_q && s_axil_wvalid) begin
                    w_held_d = 1'b1;
                    w_data_d = s_axil_wdata;
                    w_strb_d = s_axil_wstrb;
                end
                if (aw_held_q && w_held_q) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    wstate_d  = W_RESP;
                    bvalid_d  = 1'b1;
                    bresp_d   = RESP_OKAY;
                    case (wr_sel)
                        SEL_STEP: begin
                            step_shadow_d = shadow_merged[ACC_WIDTH-1:0];
                            if (|w_strb_q) pending_d = 1'b1;
                        end
                        SEL_CTRL: begin
                            if (w_strb_q[0]) ctrl_d = w_data_q[1:0];
                        end
                        SEL_COMMIT: begin
                            nco_step_d    = step_shadow_q;
                            step_update_d = 1'b1;
                            pending_d     = 1'b0;
                        end
                        default: bresp_d = RESP_SLVERR;
                    endcase
                end
            end
            W_RESP: begin
                if (s_axil_bready) begin
                    bvalid_d = 1'b0;
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase

        awready_d = (wstate_d == W_IDLE) && !aw_held_d;
        wready_d  = (wstate_d == W_IDLE) && !w_held_d;
    end

    // Read mux sees the current register contents, so a read racing a write returns the old value.
    always_comb begin
        rd_sel  = decode_addr(32'(s_axil_araddr));
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (rd_sel)
            SEL_STEP: begin
`ifdef AXIL_NCO_REGS_READBACK_EN
                rd_data = 32'(step_shadow_q);
`endif
            end
            SEL_CTRL: begin
`ifdef AXIL_NCO_REGS_READBACK_EN
                rd_data = {30'd0, ctrl_q};
`endif
            end
            SEL_STATUS: rd_data = {30'd0, pending_q, mmcm_locked};
            SEL_ID:     rd_data = ID_VALUE;
            default:    rd_resp = RESP_SLVERR;
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        case (rstate_q)
            R_IDLE: begin
                if (arready_q && s_axil_arvalid) begin
                    rstate_d = R_DATA;
                    rvalid_d = 1'b1;
                    rdata_d  = rd_data;
                    rresp_d  = rd_resp;
                end
            end
            R_DATA: begin
                if (s_axil_rready) begin
                    rstate_d = R_IDLE;
                    rvalid_d = 1'b0;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
        arready_d = (rstate_d == R_IDLE);
    end

    always_ff @(posedge aclk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wstate_q      <= W_IDLE;
            awready_q     <= 1'b0;
            wready_q      <= 1'b0;
            aw_held_q     <= 1'b0;
            w_held_q      <= 1'b0;
            aw_addr_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            bvalid_q      <= 1'b0;
            bresp_q       <= RESP_OKAY;
            rstate_q      <= R_IDLE;
            arready_q     <= 1'b0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            rresp_q       <= RESP_OKAY;
            step_shadow_q <= '0;
            nco_step_q    <= '0;
            step_update_q <= 1'b0;
            ctrl_q        <= '0;
            pending_q     <= 1'b0;
        end else begin
            wstate_q      <= wstate_d;
            awready_q     <= awready_d;
            wready_q      <= wready_d;
            aw_held_q     <= aw_held_d;
            w_held_q      <= w_held_d;
            aw_addr_q     <= aw_addr_d;
            w_data_q      <= w_data_d;
            w_strb_q      <= w_strb_d;
            bvalid_q      <= bvalid_d;
            bresp_q       <= bresp_d;
            rstate_q      <= rstate_d;
            arready_q     <= arready_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            rresp_q       <= rresp_d;
            step_shadow_q <= step_shadow_d;
            nco_step_q    <= nco_step_d;
            step_update_q <= step_update_d;
            ctrl_q        <= ctrl_d;
            pending_q     <= pending_d;
        end
    end

    assign s_axil_awready  = awready_q;
    assign s_axil_wready   = wready_q;
    assign s_axil_bvalid   = bvalid_q;
    assign s_axil_bresp    = bresp_q;
    assign s_axil_arready  = arready_q;
    assign s_axil_rvalid   = rvalid_q;
    assign s_axil_rdata    = rdata_q;
    assign s_axil_rresp    = rresp_q;
    assign nco_step        = nco_step_q;
    assign nco_step_update = step_update_q;
    assign nco_step_enable = ctrl_q[0];
    assign dither_enable   = ctrl_q[1];

endmodule

// File: tb/tb_axil_nco_regs.sv
// Directed self-checking bench for axil_nco_regs; expectations follow the
// AXIL_NCO_REGS_READBACK_EN setting of the build.
module tb_axil_nco_regs;

    localparam logic [31:0] ID_EXP = 32'h4D41_5348;
`ifdef AXIL_NCO_REGS_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        rst  = 1'b1;
    logic [7:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [7:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] nco_step;
    logic        nco_step_update;
    logic        nco_step_enable;
    logic        dither_enable;
    logic        mmcm_locked = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    axil_nco_regs #(.ACC_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .aclk            (aclk),
        .rst             (rst),
        .s_axil_awaddr   (awaddr),
        .s_axil_awvalid  (awvalid),
        .s_axil_awready  (awready),
        .s_axil_wdata    (wdata),
        .s_axil_wstrb    (wstrb),
        .s_axil_wvalid   (wvalid),
        .s_axil_wready   (wready),
        .s_axil_bresp    (bresp),
        .s_axil_bvalid   (bvalid),
        .s_axil_bready   (bready),
        .s_axil_araddr   (araddr),
        .s_axil_arvalid  (arvalid),
        .s_axil_arready  (arready),
        .s_axil_rdata    (rdata),
        .s_axil_rresp    (rresp),
        .s_axil_rvalid   (rvalid),
        .s_axil_rready   (rready),
        .nco_step        (nco_step),
        .nco_step_update (nco_step_update),
        .nco_step_enable (nco_step_enable),
        .dither_enable   (dither_enable),
        .mmcm_locked     (mmcm_locked)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
        bit aw_f, w_f, aw_done, w_done;
        int n;
        aw_done = 0; w_done = 0; n = 0;
        awaddr = addr; awvalid = 1'b1;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            tick();
            if (aw_f) begin awvalid = 1'b0; aw_done = 1; end
            if (w_f)  begin wvalid  = 1'b0; w_done  = 1; end
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1; n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        if (!bvalid) begin
            n_checks++;
            $display("FAIL write_timeout addr %h: got no bvalid, expected bvalid within 20 cycles", addr);
            resp = 2'bxx;
            bready = 1'b0;
            return;
        end
        resp = bresp;
        tick();
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        n = 0;
        araddr = addr; arvalid = 1'b1;
        while (!arready && n < 20) begin tick(); n++; end
        tick();
        arvalid = 1'b0;
        rready = 1'b1; n = 0;
        while (!rvalid && n < 20) begin tick(); n++; end
        if (!rvalid) begin
            n_checks++;
            $display("FAIL read_timeout addr %h: got no rvalid, expected rvalid within 20 cycles", addr);
            data = 'x; resp = 2'bxx;
            rready = 1'b0;
            return;
        end
        data = rdata; resp = rresp;
        tick();
        rready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata} !== '0)
            $display("FAIL reset_axi: got %h, expected 0",
                     {awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata});
        else n_pass++;
        n_checks++;
        if ({nco_step, nco_step_update, nco_step_enable, dither_enable} !== '0)
            $display("FAIL reset_nco: got %h, expected 0",
                     {nco_step, nco_step_update, nco_step_enable, dither_enable});
        else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++;
        if ({awready, wready, arready} !== 3'b111)
            $display("FAIL ready_after_reset: got %b, expected 111", {awready, wready, arready});
        else n_pass++;
    endtask

    task automatic test_shadow_write();
        logic [31:0] d; logic [1:0] r; bit extra_b;
        mmcm_locked = 1'b1;
        awaddr = 8'h00; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        tick();
        wdata = 32'h0012_3456; wstrb = 4'hF; wvalid = 1'b1;
        n_checks++;
        if (wready !== 1'b1) $display("FAIL shadow_wready: got %b, expected 1", wready);
        else n_pass++;
        tick();
        wvalid = 1'b0;
        n_checks++;
        if (bvalid !== 1'b0) $display("FAIL shadow_b_early: got %b, expected 0", bvalid);
        else n_pass++;
        tick();
        n_checks++;
        if ({bvalid, bresp} !== 3'b100) $display("FAIL shadow_b: got %b, expected 100", {bvalid, bresp});
        else n_pass++;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        extra_b = 0;
        repeat (3) begin
            if (bvalid) extra_b = 1;
            tick();
        end
        n_checks++;
        if (extra_b) $display("FAIL shadow_single_b: got extra bvalid, expected none");
        else n_pass++;
        do_read(8'h0C, d, r);
        n_checks++;
        if ({r, d} !== {2'b00, 32'h3}) $display("FAIL status_pending: got %h, expected %h", {r, d}, {2'b00, 32'h3});
        else n_pass++;
        n_checks++;
        if (nco_step !== 32'h0) $display("FAIL step_before_commit: got %h, expected 0", nco_step);
        else n_pass++;
    endtask

    task automatic test_commit();
        logic [31:0] d; logic [1:0] r;
        awaddr = 8'h08; awvalid = 1'b1;
        wdata = 32'hDEAD_BEEF; wstrb = 4'h0; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        n_checks++;
        if ({nco_step, nco_step_update} !== {32'h0, 1'b0})
            $display("FAIL commit_early: got %h/%b, expected 0/0", nco_step, nco_step_update);
        else n_pass++;
        tick();
        n_checks++;
        if ({nco_step, nco_step_update, bvalid} !== {32'h0012_3456, 1'b1, 1'b1})
            $display("FAIL commit_edge: got %h/%b/%b, expected 00123456/1/1", nco_step, nco_step_update, bvalid);
        else n_pass++;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        n_checks++;
        if ({nco_step, nco_step_update} !== {32'h0012_3456, 1'b0})
            $display("FAIL commit_pulse_end: got %h/%b, expected 00123456/0", nco_step, nco_step_update);
        else n_pass++;
        do_read(8'h0C, d, r);
        n_checks++;
        if ({r, d} !== {2'b00, 32'h1}) $display("FAIL status_cleared: got %h, expected %h", {r, d}, {2'b00, 32'h1});
        else n_pass++;
    endtask

    task automatic test_w_before_aw();
        bit stable, extra_b;
        wdata = 32'h3; wstrb = 4'h1; wvalid = 1'b1; awaddr = 8'h04;
        tick();
        wvalid = 1'b0;
        tick();
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        tick();
        stable = 1;
        repeat (5) begin
            if ({bvalid, bresp} !== 3'b100) stable = 0;
            tick();
        end
        n_checks++;
        if (!stable) $display("FAIL b_hold: got unstable bvalid/bresp %b, expected 100 for 5 cycles", {bvalid, bresp});
        else n_pass++;
        n_checks++;
        if ({nco_step_enable, dither_enable} !== 2'b11)
            $display("FAIL ctrl_enables: got %b, expected 11", {nco_step_enable, dither_enable});
        else n_pass++;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        extra_b = 0;
        repeat (4) begin
            if (bvalid) extra_b = 1;
            tick();
        end
        n_checks++;
        if (extra_b) $display("FAIL ctrl_single_b: got extra bvalid, expected none");
        else n_pass++;
    endtask

    task automatic test_read_id();
        logic [31:0] d; logic [1:0] r; bit stable;
        araddr = 8'h10; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        n_checks++;
        if ({rvalid, rresp, rdata} !== {1'b1, 2'b00, ID_EXP})
            $display("FAIL id_latency: got %b/%b/%h, expected 1/00/%h", rvalid, rresp, rdata, ID_EXP);
        else n_pass++;
        stable = 1;
        repeat (3) begin
            tick();
            if ({rvalid, rresp, rdata} !== {1'b1, 2'b00, ID_EXP}) stable = 0;
        end
        n_checks++;
        if (!stable) $display("FAIL id_hold: got %b/%h, expected stable 1/%h", rvalid, rdata, ID_EXP);
        else n_pass++;
        rready = 1'b1;
        tick();
        rready = 1'b0;
        n_checks++;
        if (rvalid !== 1'b0) $display("FAIL id_r_done: got %b, expected 0", rvalid);
        else n_pass++;
        do_read(8'h14, d, r);
        n_checks++;
        if ({r, d} !== {2'b10, 32'h0}) $display("FAIL unmapped_read: got %h, expected %h", {r, d}, {2'b10, 32'h0});
        else n_pass++;
        do_read(8'h08, d, r);
        n_checks++;
        if ({r, d} !== {2'b10, 32'h0}) $display("FAIL commit_read: got %h, expected %h", {r, d}, {2'b10, 32'h0});
        else n_pass++;
    endtask

    task automatic test_errors();
        logic [31:0] d; logic [1:0] r;
        do_write(8'h10, 32'h0, 4'hF, r);
        n_checks++;
        if (r !== 2'b10) $display("FAIL write_id_resp: got %b, expected 10", r);
        else n_pass++;
        do_write(8'h0C, 32'hFFFF_FFFF, 4'hF, r);
        n_checks++;
        if (r !== 2'b10) $display("FAIL write_status_resp: got %b, expected 10", r);
        else n_pass++;
        do_write(8'h20, 32'h0, 4'hF, r);
        n_checks++;
        if (r !== 2'b10 || {nco_step_enable, dither_enable} !== 2'b11)
            $display("FAIL write_unmapped: got %b/%b, expected 10/11", r, {nco_step_enable, dither_enable});
        else n_pass++;
        do_read(8'h0C, d, r);
        n_checks++;
        if ({r, d} !== {2'b00, 32'h1}) $display("FAIL status_after_err: got %h, expected %h", {r, d}, {2'b00, 32'h1});
        else n_pass++;
    endtask

    task automatic test_readback();
        logic [31:0] d; logic [1:0] r;
        do_write(8'h00, 32'hFFFF_FFFF, 4'hF, r);
        n_checks++;
        if (r !== 2'b00) $display("FAIL ones_write_resp: got %b, expected 00", r);
        else n_pass++;
        do_read(8'h00, d, r);
        n_checks++;
        if ({r, d} !== {2'b00, (RB ? 32'hFFFF_FFFF : 32'h0)})
            $display("FAIL shadow_readback: got %h, expected %h", {r, d}, {2'b00, (RB ? 32'hFFFF_FFFF : 32'h0)});
        else n_pass++;
        do_read(8'h05, d, r);
        n_checks++;
        if ({r, d} !== {2'b00, (RB ? 32'h3 : 32'h0)})
            $display("FAIL ctrl_readback: got %h, expected %h", {r, d}, {2'b00, (RB ? 32'h3 : 32'h0)});
        else n_pass++;
        do_write(8'h08, 32'h0, 4'hF, r);
        n_checks++;
        if ({r, nco_step} !== {2'b00, 32'hFFFF_FFFF})
            $display("FAIL commit_ones: got %h, expected %h", {r, nco_step}, {2'b00, 32'hFFFF_FFFF});
        else n_pass++;
    endtask

    task automatic test_strobe();
        logic [31:0] d; logic [1:0] r;
        do_write(8'h00, 32'hAABB_CCDD, 4'h0, r);
        do_read(8'h0C, d, r);
        n_checks++;
        if (d !== 32'h1) $display("FAIL zero_strobe_pending: got %h, expected 1", d);
        else n_pass++;
        do_write(8'h02, 32'hAABB_CCDD, 4'b0010, r);
        do_read(8'h0C, d, r);
        n_checks++;
        if (d !== 32'h3) $display("FAIL lane_strobe_pending: got %h, expected 3", d);
        else n_pass++;
        do_write(8'h08, 32'h0, 4'h0, r);
        n_checks++;
        if (nco_step !== 32'hFFFF_CCFF) $display("FAIL lane_merge: got %h, expected ffffccff", nco_step);
        else n_pass++;
        mmcm_locked = 1'b0;
        do_read(8'h0C, d, r);
        n_checks++;
        if (d !== 32'h0) $display("FAIL status_unlocked: got %h, expected 0", d);
        else n_pass++;
        mmcm_locked = 1'b1;
    endtask

    task automatic test_back_to_back();
        int hs[$]; int beats, bad;
        beats = 0; bad = 0;
        araddr = 8'h10; arvalid = 1'b1; rready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (arvalid && arready) hs.push_back(c);
            if (rvalid && rready) begin
                beats++;
                if (rdata !== ID_EXP) bad++;
            end
            tick();
        end
        arvalid = 1'b0; rready = 1'b0;
        n_checks++;
        if (hs.size() < 2 || hs[1] - hs[0] != 2)
            $display("FAIL ar_spacing: got %0d handshakes, expected spacing 2", hs.size());
        else n_pass++;
        n_checks++;
        if (beats != 5 || bad != 0) $display("FAIL b2b_beats: got %0d beats %0d bad, expected 5 beats 0 bad", beats, bad);
        else n_pass++;
    endtask

    task automatic test_read_during_write();
        logic [31:0] d; logic [1:0] r;
        awaddr = 8'h00; awvalid = 1'b1;
        wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 8'h0C; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        n_checks++;
        if ({rvalid, rdata, bvalid} !== {1'b1, 32'h1, 1'b1})
            $display("FAIL read_pre_write: got %b/%h/%b, expected 1/00000001/1", rvalid, rdata, bvalid);
        else n_pass++;
        rready = 1'b1; bready = 1'b1;
        tick();
        rready = 1'b0; bready = 1'b0;
        do_read(8'h0C, d, r);
        n_checks++;
        if (d !== 32'h3) $display("FAIL read_post_write: got %h, expected 3", d);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit early_b;
        awaddr = 8'h00; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        rst = 1'b1;
        tick();
        n_checks++;
        if ({awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata,
             nco_step, nco_step_update, nco_step_enable, dither_enable} !== '0)
            $display("FAIL mid_reset_outputs: got %h/%h, expected 0/0",
                     {awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata},
                     {nco_step, nco_step_update, nco_step_enable, dither_enable});
        else n_pass++;
        rst = 1'b0;
        tick();
        wdata = 32'h5; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        early_b = 0;
        repeat (4) begin
            if (bvalid) early_b = 1;
            tick();
        end
        n_checks++;
        if (early_b) $display("FAIL aborted_aw_b: got bvalid, expected none");
        else n_pass++;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        tick();
        n_checks++;
        if (bvalid !== 1'b1) $display("FAIL fresh_aw_b: got %b, expected 1", bvalid);
        else n_pass++;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_shadow_write();
        test_commit();
        test_w_before_aw();
        test_read_id();
        test_errors();
        test_readback();
        test_strobe();
        test_back_to_back();
        test_read_during_write();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axil_nco_regs.md
AXIL_NCO_REGS -- requirements
Module: axil_nco_regs

Interface
REQ-001 Parameter ACC_WIDTH, default 32, NCO phase-step width in bits; legal range 1..32.
REQ-002 Parameter ADDR_WIDTH, default 8, AXI4-Lite byte-address width.
REQ-003 aclk  input  1  sole clock; all logic on posedge aclk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 s_axil_awaddr/awvalid/awready  in/in/out  ADDR_WIDTH/1/1  write address channel.
REQ-006 s_axil_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel.
REQ-007 s_axil_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
REQ-008 s_axil_araddr/arvalid/arready  in/in/out  ADDR_WIDTH/1/1  read address channel.
REQ-009 s_axil_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel.
REQ-010 nco_step  output  ACC_WIDTH  committed NCO phase step.
REQ-011 nco_step_update  output  1  one-cycle pulse when nco_step changes via commit.
REQ-012 nco_step_enable, dither_enable  output  1 each  CTRL register bits.
REQ-013 mmcm_locked  input  1  status bit, already synchronous to aclk.

Function
REQ-014 Register map (word-aligned, addr[1:0] ignored): 0x00 STEP_SHADOW RW; 0x04 CTRL RW (bit0 nco_step_enable, bit1 dither_enable); 0x08 COMMIT WO; 0x0C STATUS RO (bit0 mmcm_locked, bit1 shadow_pending); 0x10 ID RO = 0x4D415348.
REQ-015 Write FSM states W_IDLE, W_RESP: in W_IDLE awready and wready assert independently until each beat is captured; AW and W may arrive in either order or the same cycle.
REQ-016 The cycle after both AW and W are held, the register write occurs and FSM enters W_RESP with bvalid=1; bvalid holds until bready; then return to W_IDLE; one write outstanding at most.
REQ-017 WSTRB byte lanes honored on STEP_SHADOW and CTRL; bits at or above ACC_WIDTH are write-ignored and read 0.
REQ-018 Any write to COMMIT (data ignored): nco_step <= STEP_SHADOW next cycle, nco_step_update pulses high that same cycle, shadow_pending clears.
REQ-019 Any write to STEP_SHADOW with a nonzero strobe sets shadow_pending.
REQ-020 Read FSM states R_IDLE, R_DATA: arready=1 only in R_IDLE; on AR handshake, rdata/rresp register and rvalid asserts next cycle, held stable until rready.
REQ-021 Read latency is exactly one cycle AR-handshake to rvalid; back-to-back reads allow one AR per two cycles minimum.
REQ-022 Unmapped address, write to STATUS/ID, or read of COMMIT: resp=SLVERR (2'b10), no state change, rdata=0; otherwise OKAY (2'b00).
REQ-023 Read and write channels operate independently; a read captured in the same cycle as a write update returns the pre-write value.
REQ-024 All outputs registered; no combinational path from any AXI input to any output.

Reset
REQ-025 During rst: all ready/valid outputs 0, bresp/rresp/rdata 0, FSMs to W_IDLE/R_IDLE, partial AW/W captures discarded.
REQ-026 Reset values: STEP_SHADOW 0, nco_step 0, nco_step_update 0, nco_step_enable 0, dither_enable 0, shadow_pending 0.
REQ-027 Reset asserted mid-transaction aborts it silently; no B or R beat is issued for it.

Configuration
REQ-028 Macro AXIL_NCO_REGS_READBACK_EN defined: STEP_SHADOW and CTRL read back stored values.
REQ-029 Macro undefined: reads of STEP_SHADOW and CTRL return 0 with OKAY; STATUS and ID unaffected; handshake timing identical.

Structure
REQ-030 Package nco_regs_pkg holds register offset constants, ID constant, AXI resp codes, and write/read FSM state enums.
REQ-031 Single module, no sub-module; both FSMs and the register file live in axil_nco_regs.

Verification
REQ-032 AW then W two cycles later to 0x00 data 0x00123456 strobe 0xF -> one bvalid OKAY; STATUS reads 0x3 with mmcm_locked=1; nco_step still 0.
REQ-033 Write COMMIT -> nco_step=0x00123456 and one-cycle nco_step_update on the same edge; STATUS bit1=0.
REQ-034 W before AW, CTRL data 0x3 strobe 0x1, bready held low 5 cycles -> bvalid stable 5 cycles, both enables=1, no second B.
REQ-035 Read 0x10 with rready low 3 cycles -> rdata=0x4D415348 stable, OKAY; read 0x14 -> SLVERR, rdata 0.
REQ-036 rst asserted after AW captured, before W -> no bvalid, all outputs at reset values next cycle.
REQ-037 Build without AXIL_NCO_REGS_READBACK_EN, write STEP_SHADOW 0xFFFFFFFF -> read returns 0 OKAY; after commit nco_step all-ones.
